cond_exec_ctrl: RTL and testbench
=================================

COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2 (range 1-7): wrong-path slots discarded after a taken branch.
REQ-002 SHALL have port clk input 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: upstream valid/ready handshake.
REQ-005 SHALL have port in_cond input 4: ARM condition field of the offered instruction.
REQ-006 SHALL have ports in_s input 1, in_branch input 1, in_wb_en input 1, in_mem_r input 1, in_mem_w input 1: instruction control bits.
REQ-007 SHALL have port in_alu_nzcv input 4: {N,Z,C,V} produced by this instruction's ALU operation.
REQ-008 SHALL have ports sr_wr_en input 1 and sr_wr_data input 4: direct status-register write (MSR path).
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: downstream handshake.
REQ-010 SHALL have ports out_exec, out_wb_en, out_mem_r, out_mem_w, out_branch_taken, all output 1: registered gated controls.
REQ-011 SHALL have ports flush output 1, status output 4 ({N,Z,C,V}), exec_cnt output 16, squash_cnt output 16.

Function
REQ-012 Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (combinational).
REQ-013 Condition pass SHALL be evaluated on status (the register value before this edge): 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 and 1111 always 1.
REQ-014 FSM states: RUN, FLUSH; reset state RUN.
REQ-015 RUN, accept: out_valid<=1; out_exec<=pass; out_wb_en/out_mem_r/out_mem_w <= in_* & pass; out_branch_taken <= in_branch & pass.
REQ-016 RUN, accept, pass & in_s: status <= in_alu_nzcv at the same edge.
REQ-017 RUN, accept, pass & in_branch: flush high for exactly the next cycle; state -> FLUSH; flush counter <= FLUSH_CYCLES.
REQ-018 FLUSH: in_ready follows REQ-012; each accept is discarded: no out_valid, no status update, counters unchanged; counter decrements per discard; state -> RUN when an accept brings it from 1 to 0.
REQ-019 Downstream stall (out_valid & !out_ready): all out_* held, no accept, FSM and flush counter held.
REQ-020 out_valid & out_ready with no new accept: out_valid<=0, all other out_* <=0.
REQ-021 exec_cnt increments on each RUN accept with pass; squash_cnt on each RUN accept with !pass; both saturate at 16'hFFFF.
REQ-022 sr_wr_en=1 SHALL load status <= sr_wr_data, taking priority over a simultaneous REQ-016 update; the evaluation of the same-edge instruction still uses the old status.
REQ-023 A failed-condition instruction SHALL still produce out_valid=1 with out_exec=0 and all enables 0 (bubble), and SHALL NOT update status or trigger flush.

Reset
REQ-024 rst high SHALL immediately force: state RUN, flush counter 0, status 4'b0000, out_valid 0, all out_* 0, flush 0, exec_cnt 0, squash_cnt 0.
REQ-025 Reset asserted mid-FLUSH or mid-stall SHALL abandon it; first post-reset accept is handled in RUN.

Verification
REQ-026 status=0100 (Z=1), accept cond=0000, in_wb_en=1 -> next cycle out_valid=1, out_exec=1, out_wb_en=1, exec_cnt=1.
REQ-027 status=0000, accept cond=0000, in_s=1, in_alu_nzcv=1111 -> out_exec=0, out_wb_en=0, status stays 0000, squash_cnt=1.
REQ-028 Accept cond=1110, in_branch=1, then offer 3 valid instructions with FLUSH_CYCLES=2 -> flush=1 for one cycle, out_branch_taken=1, first two discarded, third emerges with out_valid=1.
REQ-029 out_ready=0 for 4 cycles while out_valid=1 -> in_ready=0, outputs stable, counters unchanged; release -> one transfer, then next accept.
REQ-030 Same edge: sr_wr_en=1 with data 1010, accept in_s=1, cond=1110, in_alu_nzcv=0101 -> status=1010.
REQ-031 rst pulse during FLUSH with flush counter=2 -> all outputs and counters 0, state RUN; next branch-free accept emerges normally.

Source files
------------

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution gate: evaluates ARM condition codes against the
// status register, squashes failed instructions and discards wrong-path slots.
module cond_exec_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cond,
    input  logic        in_s,
    input  logic        in_branch,
    input  logic        in_wb_en,
    input  logic        in_mem_r,
    input  logic        in_mem_w,
    input  logic [3:0]  in_alu_nzcv,
    input  logic        sr_wr_en,
    input  logic [3:0]  sr_wr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_exec,
    output logic        out_wb_en,
    output logic        out_mem_r,
    output logic        out_mem_w,
    output logic        out_branch_taken,
    output logic        flush,
    output logic [3:0]  status,
    output logic [15:0] exec_cnt,
    output logic [15:0] squash_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [3:0]  status_q, status_d;
    logic        vld_q, vld_d;
    logic        exec_q, exec_d;
    logic        wb_q, wb_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic        bt_q, bt_d;
    logic        flush_q, flush_d;
    logic [15:0] ecnt_q, ecnt_d;
    logic [15:0] scnt_q, scnt_d;
    logic        accept;
    logic        pass;
    logic        n, z, c, v;

    assign {n, z, c, v} = status_q;
    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        pass = 1'b1;
        case (in_cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c && !z;
            4'b1001: pass = !c || z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z && (n == v);
            4'b1101: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        status_d = status_q;
        vld_d    = vld_q;
        exec_d   = exec_q;
        wb_d     = wb_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        bt_d     = bt_q;
        flush_d  = 1'b0;
        ecnt_d   = ecnt_q;
        scnt_d   = scnt_q;
        // Outputs only move when the downstream slot is free
        if (in_ready) begin
            vld_d  = 1'b0;
            exec_d = 1'b0;
            wb_d   = 1'b0;
            mr_d   = 1'b0;
            mw_d   = 1'b0;
            bt_d   = 1'b0;
            if (accept) begin
                case (state_q)
                    RUN: begin
                        vld_d  = 1'b1;
                        exec_d = pass;
                        wb_d   = in_wb_en && pass;
                        mr_d   = in_mem_r && pass;
                        mw_d   = in_mem_w && pass;
                        bt_d   = in_branch && pass;
                        if (pass) begin
                            if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
                            if (in_s) status_d = in_alu_nzcv;
                            if (in_branch) begin
                                flush_d = 1'b1;
                                state_d = FLUSH;
                                fcnt_d  = 3'(FLUSH_CYCLES);
                            end
                        end else if (scnt_q != 16'hFFFF) begin
                            scnt_d = scnt_q + 16'd1;
                        end
                    end
                    FLUSH: begin
                        fcnt_d = fcnt_q - 3'd1;
                        if (fcnt_q == 3'd1) state_d = RUN;
                    end
                    default: state_d = RUN;
                endcase
            end
        end
        // MSR write wins over a same-edge flag update
        if (sr_wr_en) status_d = sr_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            fcnt_q   <= 3'd0;
            status_q <= 4'b0000;
            vld_q    <= 1'b0;
            exec_q   <= 1'b0;
            wb_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
            flush_q  <= 1'b0;
            ecnt_q   <= 16'd0;
            scnt_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            status_q <= status_d;
            vld_q    <= vld_d;
            exec_q   <= exec_d;
            wb_q     <= wb_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            bt_q     <= bt_d;
            flush_q  <= flush_d;
            ecnt_q   <= ecnt_d;
            scnt_q   <= scnt_d;
        end
    end

    assign out_valid        = vld_q;
    assign out_exec         = exec_q;
    assign out_wb_en        = wb_q;
    assign out_mem_r        = mr_q;
    assign out_mem_w        = mw_q;
    assign out_branch_taken = bt_q;
    assign flush            = flush_q;
    assign status           = status_q;
    assign exec_cnt         = ecnt_q;
    assign squash_cnt       = scnt_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl: condition table vectors plus
// branch-flush, stall and reset-mid-flush sequences.
module tb_cond_exec_ctrl;

    localparam int FC = 2;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_cond;
    logic        in_s, in_branch, in_wb_en, in_mem_r, in_mem_w;
    logic [3:0]  in_alu_nzcv;
    logic        sr_wr_en;
    logic [3:0]  sr_wr_data;
    logic        out_valid, out_ready;
    logic        out_exec, out_wb_en, out_mem_r, out_mem_w, out_branch_taken;
    logic        flush;
    logic [3:0]  status;
    logic [15:0] exec_cnt, squash_cnt;

    cond_exec_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_s(in_s), .in_branch(in_branch),
        .in_wb_en(in_wb_en), .in_mem_r(in_mem_r), .in_mem_w(in_mem_w),
        .in_alu_nzcv(in_alu_nzcv),
        .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exec(out_exec), .out_wb_en(out_wb_en),
        .out_mem_r(out_mem_r), .out_mem_w(out_mem_w),
        .out_branch_taken(out_branch_taken),
        .flush(flush), .status(status),
        .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pre;
        logic [3:0] cond;
        logic       s, br, wb, mr, mw;
        logic [3:0] nzcv;
        logic       srw;
        logic [3:0] srd;
        logic [5:0] xctl;
        logic [3:0] xst;
    } vec_t;

    vec_t vecs[19];
    int checks = 0;
    int failures = 0;
    int exec_exp = 0;
    int squash_exp = 0;
    logic [6:0] ctl;

    assign ctl = {out_valid, out_exec, out_wb_en, out_mem_r,
                  out_mem_w, out_branch_taken, flush};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] c, input logic s,
                       input logic br, input logic wb, input logic mr,
                       input logic mw, input logic [3:0] nz,
                       input logic srw, input logic [3:0] srd);
        in_valid = v; in_cond = c; in_s = s; in_branch = br;
        in_wb_en = wb; in_mem_r = mr; in_mem_w = mw;
        in_alu_nzcv = nz; sr_wr_en = srw; sr_wr_data = srd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_exec_cnt"}, 32'(exec_cnt), 32'(exec_exp));
        chk({name, "_squash_cnt"}, 32'(squash_cnt), 32'(squash_exp));
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 4'b0000, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b110000, 4'b0100};
        vecs[1]  = '{4'b0000, 4'b0000, 1,0,1,0,0, 4'b1111, 0, 4'b0000, 6'b000000, 4'b0000};
        vecs[2]  = '{4'b0000, 4'b0001, 1,0,0,1,0, 4'b0011, 0, 4'b0000, 6'b101000, 4'b0011};
        vecs[3]  = '{4'b0010, 4'b1000, 0,0,0,0,1, 4'b0000, 0, 4'b0000, 6'b100100, 4'b0010};
        vecs[4]  = '{4'b0110, 4'b1000, 0,0,0,0,1, 4'b0000, 0, 4'b0000, 6'b000000, 4'b0110};
        vecs[5]  = '{4'b0110, 4'b1001, 0,0,0,0,1, 4'b0000, 0, 4'b0000, 6'b100100, 4'b0110};
        vecs[6]  = '{4'b1000, 4'b1010, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b000000, 4'b1000};
        vecs[7]  = '{4'b1000, 4'b1011, 1,0,1,0,0, 4'b0110, 0, 4'b0000, 6'b110000, 4'b0110};
        vecs[8]  = '{4'b1001, 4'b1100, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b110000, 4'b1001};
        vecs[9]  = '{4'b1101, 4'b1101, 0,0,0,1,0, 4'b0000, 0, 4'b0000, 6'b101000, 4'b1101};
        vecs[10] = '{4'b0001, 4'b0111, 1,0,1,0,0, 4'b1111, 0, 4'b0000, 6'b000000, 4'b0001};
        vecs[11] = '{4'b0001, 4'b0110, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b110000, 4'b0001};
        vecs[12] = '{4'b0000, 4'b1110, 1,0,1,0,0, 4'b0101, 1, 4'b1010, 6'b110000, 4'b1010};
        vecs[13] = '{4'b0100, 4'b0001, 1,0,1,0,0, 4'b1111, 1, 4'b0000, 6'b000000, 4'b0000};
        vecs[14] = '{4'b0000, 4'b0000, 0,1,0,0,0, 4'b0000, 0, 4'b0000, 6'b000000, 4'b0000};
        vecs[15] = '{4'b1000, 4'b1111, 0,1,1,0,0, 4'b0000, 0, 4'b0000, 6'b110011, 4'b1000};
        vecs[16] = '{4'b1000, 4'b0101, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b000000, 4'b1000};
        vecs[17] = '{4'b0000, 4'b0011, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b110000, 4'b0000};
        vecs[18] = '{4'b1100, 4'b1100, 0,0,1,0,0, 4'b0000, 0, 4'b0000, 6'b000000, 4'b1100};

        rst = 1'b1;
        out_ready = 1'b1;
        drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
        #12;
        chk("reset_ctl", 32'(ctl), 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        chk_cnt("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 19; i++) begin
            drv(0, 4'h0, 0,0,0,0,0, 4'h0, 1, vecs[i].pre);
            step();
            drv(1, vecs[i].cond, vecs[i].s, vecs[i].br, vecs[i].wb,
                vecs[i].mr, vecs[i].mw, vecs[i].nzcv,
                vecs[i].srw, vecs[i].srd);
            step();
            drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
            if (vecs[i].xctl[5]) exec_exp++;
            else squash_exp++;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'({1'b1, vecs[i].xctl}));
            chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].xst));
            chk_cnt($sformatf("vec%0d", i));
            if (vecs[i].xctl[0]) begin
                for (int k = 0; k < FC; k++) begin
                    drv(1, 4'b1110, 0,0,1,0,0, 4'h0, 0, 4'h0);
                    step();
                    chk($sformatf("vec%0d_drain%0d_ctl", i, k), 32'(ctl), 32'd0);
                    chk_cnt($sformatf("vec%0d_drain%0d", i, k));
                end
                drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
            end
        end

        // Taken branch then three offered instructions
        drv(0, 4'h0, 0,0,0,0,0, 4'h0, 1, 4'b0000);
        step();
        drv(1, 4'b1110, 0,1,1,0,0, 4'h0, 0, 4'h0);
        step();
        exec_exp++;
        chk("br_ctl", 32'(ctl), 32'(7'b1110011));
        drv(1, 4'b1110, 0,0,1,0,0, 4'h0, 0, 4'h0);
        step();
        chk("br_slot1_ctl", 32'(ctl), 32'd0);
        step();
        chk("br_slot2_ctl", 32'(ctl), 32'd0);
        chk_cnt("br_slot2");
        step();
        exec_exp++;
        chk("br_slot3_ctl", 32'(ctl), 32'(7'b1110000));
        chk_cnt("br_slot3");
        drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
        step();

        // Downstream stall for four cycles
        drv(1, 4'b1110, 0,0,1,0,0, 4'h0, 0, 4'h0);
        step();
        exec_exp++;
        out_ready = 1'b0;
        drv(1, 4'b1110, 0,0,0,0,1, 4'h0, 0, 4'h0);
        #1;
        chk("stall_in_ready0", 32'(in_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_ctl", k), 32'(ctl), 32'(7'b1110000));
            chk_cnt($sformatf("stall%0d", k));
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        step();
        exec_exp++;
        chk("release_ctl", 32'(ctl), 32'(7'b1100100));
        chk_cnt("release");
        drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
        step();
        chk("release_idle_ctl", 32'(ctl), 32'd0);

        // Reset while flushing with counter at FLUSH_CYCLES
        drv(1, 4'b1110, 1,1,1,0,0, 4'b1010, 0, 4'h0);
        step();
        exec_exp++;
        drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
        chk("prerst_ctl", 32'(ctl), 32'(7'b1110011));
        chk("prerst_status", 32'(status), 32'(4'b1010));
        #1;
        rst = 1'b1;
        #1;
        exec_exp = 0;
        squash_exp = 0;
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk_cnt("rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        drv(1, 4'b1110, 0,0,1,0,0, 4'h0, 0, 4'h0);
        step();
        exec_exp++;
        chk("postrst_ctl", 32'(ctl), 32'(7'b1110000));
        chk_cnt("postrst");
        drv(0, 4'h0, 0,0,0,0,0, 4'h0, 0, 4'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
